// File: rtl/comparator_if.sv
// Sample/result bundle for the registered magnitude comparator.
// The master drives operands and reads results; the slave is the comparator.
interface comparator_if #(
    parameter int unsigned WIDTH = 2
);
    logic             in_valid;
    logic             signed_mode;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             out_valid;
    logic             G;
    logic             E;
    logic             L;
    logic [WIDTH-1:0] MAX;
    logic [WIDTH-1:0] MIN;

    modport master (
        output in_valid, signed_mode, A, B,
        input  out_valid, G, E, L, MAX, MIN
    );

    modport slave (
        input  in_valid, signed_mode, A, B,
        output out_valid, G, E, L, MAX, MIN
    );
endinterface

// File: rtl/comparator.sv
// Registered unsigned/two's-complement magnitude comparator with one-cycle latency.
// Flags and MAX/MIN hold their last result while no new sample is presented.
module comparator #(
    parameter int unsigned WIDTH = 2
) (
    input logic         clk,
    input logic         rst,
    comparator_if.slave bus
);
    logic [WIDTH-1:0] sign_mask;
    logic [WIDTH-1:0] a_key;
    logic [WIDTH-1:0] b_key;
    logic             a_gt_b;
    logic             a_eq_b;

    logic             out_valid_d, out_valid_q;
    logic             g_d, g_q;
    logic             e_d, e_q;
    logic             l_d, l_q;
    logic [WIDTH-1:0] max_d, max_q;
    logic [WIDTH-1:0] min_d, min_q;

    // Flipping the sign bit maps two's-complement order onto unsigned order.
    always_comb begin
        sign_mask            = '0;
        sign_mask[WIDTH-1]   = bus.signed_mode;
        a_key                = bus.A ^ sign_mask;
        b_key                = bus.B ^ sign_mask;
        a_gt_b               = a_key > b_key;
        a_eq_b               = bus.A == bus.B;
    end

    always_comb begin
        out_valid_d = bus.in_valid;
        g_d         = g_q;
        e_d         = e_q;
        l_d         = l_q;
        max_d       = max_q;
        min_d       = min_q;
        if (bus.in_valid) begin
            g_d = a_gt_b;
            e_d = a_eq_b;
            l_d = !a_gt_b && !a_eq_b;
            // Ties resolve to MAX=A, MIN=B.
            if (a_gt_b || a_eq_b) begin
                max_d = bus.A;
                min_d = bus.B;
            end else begin
                max_d = bus.B;
                min_d = bus.A;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            g_q         <= 1'b0;
            e_q         <= 1'b0;
            l_q         <= 1'b0;
            max_q       <= '0;
            min_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            g_q         <= g_d;
            e_q         <= e_d;
            l_q         <= l_d;
            max_q       <= max_d;
            min_q       <= min_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.G         = g_q;
    assign bus.E         = e_q;
    assign bus.L         = l_q;
    assign bus.MAX       = max_q;
    assign bus.MIN       = min_q;
endmodule

// File: tb/tb_comparator.sv
// Scoreboard bench: drives a WIDTH=2 and a WIDTH=8 comparator with shared stimulus
// and checks every output field one cycle after each drive.
module tb_comparator;
    typedef struct packed {
        logic        v;
        logic        g;
        logic        e;
        logic        l;
        logic [31:0] mx;
        logic [31:0] mn;
    } exp_t;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    exp_t q2[$];
    exp_t q8[$];
    exp_t last2;
    exp_t last8;

    comparator_if #(.WIDTH(2)) bus2 ();
    comparator_if #(.WIDTH(8)) bus8 ();

    comparator #(.WIDTH(2)) u_dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    comparator #(.WIDTH(8)) u_dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Reference: values taken as integers, signed ones sign-extended arithmetically.
    function automatic exp_t model(input int w, input exp_t prev, input logic r, input logic v,
                                   input logic sm, input logic [31:0] a, input logic [31:0] b);
        longint mask;
        longint ua;
        longint ub;
        longint ka;
        longint kb;
        exp_t   n;
        mask = (longint'(1) << w) - 1;
        ua   = longint'(a) & mask;
        ub   = longint'(b) & mask;
        ka   = ua;
        kb   = ub;
        if (sm) begin
            if (((ua >> (w - 1)) & 1) != 0) ka = ua - (longint'(1) << w);
            if (((ub >> (w - 1)) & 1) != 0) kb = ub - (longint'(1) << w);
        end
        n   = prev;
        n.v = 1'b0;
        if (r) begin
            n = '0;
        end else if (v) begin
            n.v  = 1'b1;
            n.g  = ka > kb;
            n.e  = ua == ub;
            n.l  = ka < kb;
            n.mx = 32'((ka >= kb) ? ua : ub);
            n.mn = 32'((ka >= kb) ? ub : ua);
        end
        return n;
    endfunction

    task automatic compare_out(input string tag, input exp_t e, input logic v, input logic g,
                               input logic eq, input logic l, input logic [31:0] mx,
                               input logic [31:0] mn);
        check_eq({tag, ".out_valid"}, 32'(v), 32'(e.v));
        check_eq({tag, ".G"}, 32'(g), 32'(e.g));
        check_eq({tag, ".E"}, 32'(eq), 32'(e.e));
        check_eq({tag, ".L"}, 32'(l), 32'(e.l));
        check_eq({tag, ".MAX"}, mx, e.mx);
        check_eq({tag, ".MIN"}, mn, e.mn);
        if (v) check_eq({tag, ".onehot"}, 32'($countones({g, eq, l})), 32'd1);
    endtask

    task automatic step(input string tag, input logic r, input logic v, input logic sm,
                        input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        @(negedge clk);
        rst              = r;
        bus2.in_valid    = v;
        bus2.signed_mode = sm;
        bus2.A           = a[1:0];
        bus2.B           = b[1:0];
        bus8.in_valid    = v;
        bus8.signed_mode = sm;
        bus8.A           = a[7:0];
        bus8.B           = b[7:0];
        last2 = model(2, last2, r, v, sm, a, b);
        last8 = model(8, last8, r, v, sm, a, b);
        q2.push_back(last2);
        q8.push_back(last8);
        @(posedge clk);
        #1;
        if (q2.size() == 0) begin
            check_eq({tag, ".w2_queue"}, 32'd0, 32'd1);
        end else begin
            e = q2.pop_front();
            compare_out({tag, ".w2"}, e, bus2.out_valid, bus2.G, bus2.E, bus2.L,
                        32'(bus2.MAX), 32'(bus2.MIN));
        end
        if (q8.size() == 0) begin
            check_eq({tag, ".w8_queue"}, 32'd0, 32'd1);
        end else begin
            e = q8.pop_front();
            compare_out({tag, ".w8"}, e, bus8.out_valid, bus8.G, bus8.E, bus8.L,
                        32'(bus8.MAX), 32'(bus8.MIN));
        end
    endtask

    initial begin
        n_tests          = 0;
        n_fail           = 0;
        last2            = '0;
        last8            = '0;
        rst              = 1'b1;
        bus2.in_valid    = 1'b0;
        bus2.signed_mode = 1'b0;
        bus2.A           = '0;
        bus2.B           = '0;
        bus8.in_valid    = 1'b0;
        bus8.signed_mode = 1'b0;
        bus8.A           = '0;
        bus8.B           = '0;

        step("reset0", 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        step("reset1", 1'b1, 1'b1, 1'b0, 32'd2, 32'd1);
        check_eq("reset_flags", 32'({bus2.G, bus2.E, bus2.L}), 32'd0);

        for (int i = 0; i < 16; i++) begin
            step("sweep", 1'b0, 1'b1, 1'b0, 32'(i >> 2), 32'(i & 3));
        end

        step("sgn", 1'b0, 1'b1, 1'b1, 32'd2, 32'd1);
        check_eq("sgn_L", 32'(bus2.L), 32'd1);
        check_eq("sgn_MAX", 32'(bus2.MAX), 32'd1);
        check_eq("sgn_MIN", 32'(bus2.MIN), 32'd2);
        step("uns", 1'b0, 1'b1, 1'b0, 32'd2, 32'd1);
        check_eq("uns_G", 32'(bus2.G), 32'd1);
        check_eq("uns_MAX", 32'(bus2.MAX), 32'd2);
        check_eq("uns_MIN", 32'(bus2.MIN), 32'd1);

        step("eq_s", 1'b0, 1'b1, 1'b1, 32'd3, 32'd3);
        step("eq_u", 1'b0, 1'b1, 1'b0, 32'd3, 32'd3);
        check_eq("eq_E", 32'(bus2.E), 32'd1);

        step("hold_cap", 1'b0, 1'b1, 1'b0, 32'd1, 32'd0);
        for (int i = 0; i < 3; i++) step("hold", 1'b0, 1'b0, 1'b0, 32'd3, 32'd3);
        check_eq("hold_G", 32'(bus2.G), 32'd1);
        step("gap_next", 1'b0, 1'b1, 1'b0, 32'd0, 32'd1);
        check_eq("gap_L", 32'(bus2.L), 32'd1);

        step("mid_rst", 1'b1, 1'b1, 1'b0, 32'd3, 32'd0);
        check_eq("mid_rst_valid", 32'(bus2.out_valid), 32'd0);
        step("post_rst", 1'b0, 1'b1, 1'b0, 32'd3, 32'd0);

        step("w8_sgn", 1'b0, 1'b1, 1'b1, 32'h80, 32'h7F);
        check_eq("w8_sgn_L", 32'(bus8.L), 32'd1);
        step("w8_uns", 1'b0, 1'b1, 1'b0, 32'h80, 32'h7F);
        check_eq("w8_uns_G", 32'(bus8.G), 32'd1);

        for (int i = 0; i < 40; i++) begin
            step("rand", 1'b0, 1'($urandom_range(0, 3) != 0), 1'($urandom), $urandom, $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
